// File: rtl/cbus_arbiter_pkg.sv
// cbus_arbiter_pkg: cbus request/response types, arbiter state enum and sizing helpers
package cbus_arbiter_pkg;

    localparam int CBUS_ARB_MAX_INPUTS = 8;
    localparam int CBUS_ADDR_W = 32;
    localparam int CBUS_DATA_W = 32;

    typedef enum logic [2:0] {
        MLEN1  = 3'd0,
        MLEN2  = 3'd1,
        MLEN4  = 3'd2,
        MLEN8  = 3'd3,
        MLEN16 = 3'd4
    } cbus_len_t;

    typedef struct packed {
        logic                     valid;
        logic                     is_write;
        logic [1:0]               size;
        logic [CBUS_ADDR_W-1:0]   addr;
        logic [CBUS_DATA_W/8-1:0] strb;
        logic [CBUS_DATA_W-1:0]   data;
        cbus_len_t                len;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int cbus_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Distance of idx after last in circular order; 0 means immediately after last
    function automatic int rr_dist(input int idx, input int last, input int n);
        return (idx - last - 1 + n) % n;
    endfunction

endpackage

// File: rtl/cbus_arb_picker.sv
// cbus_arb_picker: combinational winner select; round-robin with CBUS_ARB_ROUND_ROBIN_EN, else fixed priority
module cbus_arb_picker
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_W      = 1
) (
    input  logic [NUM_INPUTS-1:0] valid_i,
    input  logic [IDX_W-1:0]      last_owner_i,
    output logic                  grant_valid_o,
    output logic [IDX_W-1:0]      grant_idx_o
);

    assign grant_valid_o = |valid_i;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    int best_dist;

    // Nearest valid index after the previous owner wins, so the last owner ranks lowest
    always_comb begin
        best_dist = NUM_INPUTS;
        grant_idx_o = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (valid_i[i] && rr_dist(i, int'(last_owner_i), NUM_INPUTS) < best_dist) begin
                best_dist = rr_dist(i, int'(last_owner_i), NUM_INPUTS);
                grant_idx_o = IDX_W'(i);
            end
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner_i;

    // Lowest valid index wins
    always_comb begin
        grant_idx_o = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (valid_i[i]) grant_idx_o = IDX_W'(i);
        end
    end
`endif

endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: grants whole cbus transactions to one of NUM_INPUTS masters; CBUS_ARB_ROUND_ROBIN_EN selects round-robin picking
module cbus_arbiter
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs  [NUM_INPUTS],
    output cbus_resp_t iresps [NUM_INPUTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    localparam int IDX_W = cbus_idx_w(NUM_INPUTS);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      last_owner_q, last_owner_d;
    logic [NUM_INPUTS-1:0] valid_vec;
    logic                  grant_valid;
    logic [IDX_W-1:0]      grant_idx;

    // Gather request valids for the picker
    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NUM_INPUTS; i++) valid_vec[i] = ireqs[i].valid;
    end

    cbus_arb_picker #(
        .NUM_INPUTS(NUM_INPUTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .valid_i      (valid_vec),
        .last_owner_i (last_owner_q),
        .grant_valid_o(grant_valid),
        .grant_idx_o  (grant_idx)
    );

    // State, owner and last-owner registers; reset drops the grant immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_INPUTS - 1);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Grant from IDLE, release on the accepted last beat; the IDLE cycle after release is the bubble
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        if (state_q == IDLE) begin
            if (grant_valid) begin
                state_d = BUSY;
                owner_d = grant_idx;
            end
        end else if (oresp.ready && oresp.last) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
        end
    end

    // Owner's request passes straight through; only the owner sees the memory response
    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_INPUTS; i++) iresps[i] = '0;
        if (state_q == BUSY) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (owner_q == IDX_W'(i)) begin
                    oreq      = ireqs[i];
                    iresps[i] = oresp;
                end
            end
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed stimulus with a beat scoreboard for cbus_arbiter (CBUS_ARB_ROUND_ROBIN_EN changes the expected grant order)
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    localparam int N = 2;

    typedef struct {
        int          m;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  ireqs  [N];
    cbus_resp_t iresps [N];
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_checks = 0;
    int    n_fail = 0;
    int    beats_seen = 0;
    int    order [4];

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h8000_0080;
    localparam logic [31:0] A4 = 32'h8000_0400;
    localparam logic [31:0] A5 = 32'h8000_0500;
    localparam logic [31:0] A6 = 32'h8000_0600;

    always #5 clk = ~clk;

    cbus_arbiter #(.NUM_INPUTS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .ireqs (ireqs),
        .iresps(iresps),
        .oreq  (oreq),
        .oresp (oresp)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic resp_nz();
        logic r = 1'b0;
        for (int i = 0; i < N; i++) r = r | (|iresps[i]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int m, input logic v, input logic w, input logic [31:0] a, input cbus_len_t l);
        ireqs[m].valid    = v;
        ireqs[m].is_write = w;
        ireqs[m].size     = 2'b10;
        ireqs[m].addr     = a;
        ireqs[m].strb     = 4'hf;
        ireqs[m].data     = a ^ 32'h5a5a_0000;
        ireqs[m].len      = l;
    endtask

    task automatic resp(input logic r, input logic l, input logic [31:0] d, input int m);
        oresp.ready = r;
        oresp.last  = l;
        oresp.data  = d;
        if (r) exp_q.push_back('{m, d, l});
    endtask

    // Scoreboard monitor: every beat delivered to a master must match the next expected beat
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (iresps[i].ready) begin
                    beats_seen++;
                    chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("beat_master", i, mon_e.m);
                        chk("beat_data", iresps[i].data, mon_e.data);
                        chk("beat_last", 32'(iresps[i].last), 32'(mon_e.last));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int seen0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
        order = '{0, 1, 0, 1};
`else
        order = '{0, 0, 0, 0};
`endif
        reset = 1'b1;
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        oresp = '{ready: 1'b1, last: 1'b1, data: 32'hdead_beef};
        req(0, 1, 0, A0, MLEN1);
        #1;
        chk("rst_oreq_zero", 32'(|oreq), 32'd0);
        chk("rst_iresps_zero", 32'(resp_nz()), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_owner", 32'(dut.owner_q), 32'd0);
        chk("rst_last_owner", 32'(dut.last_owner_q), 32'(N - 1));
        oresp = '0;
        ireqs[0] = '0;
        tick();
        tick();
        reset = 1'b0;

        // Single master 16-beat read
        req(1, 1, 0, A1, MLEN16);
        #1;
        chk("t1_same_cycle_valid", 32'(oreq.valid), 32'd0);
        tick();
        chk("t1_latency_valid", 32'(oreq.valid), 32'd1);
        chk("t1_addr", oreq.addr, A1);
        chk("t1_len", 32'(oreq.len), 32'(MLEN16));
        for (int i = 0; i < 16; i++) begin
            resp(1, i == 15, 32'h1100_0000 + i, 1);
            #1;
            chk("t1_m0_quiet", 32'(|iresps[0]), 32'd0);
            tick();
        end
        req(1, 0, 0, A1, MLEN16);
        oresp = '0;
        #1;
        chk("t1_idle_after", 32'(dut.state_q), 32'(IDLE));
        tick();
        chk("t1_stays_idle", 32'(oreq.valid), 32'd0);

        // Contention: both valid together
        req(0, 1, 0, A0, MLEN4);
        req(1, 1, 0, A1, MLEN2);
        tick();
        chk("t2_first_addr", oreq.addr, A0);
        for (int i = 0; i < 4; i++) begin
            resp(1, i == 3, 32'h2200_0000 + i, 0);
            tick();
        end
        req(0, 0, 0, A0, MLEN4);
        oresp = '0;
        #1;
        chk("t2_bubble", 32'(oreq.valid), 32'd0);
        tick();
        chk("t2_second_valid", 32'(oreq.valid), 32'd1);
        chk("t2_second_addr", oreq.addr, A1);
        for (int i = 0; i < 2; i++) begin
            resp(1, i == 1, 32'h2300_0000 + i, 1);
            tick();
        end
        req(1, 0, 0, A1, MLEN2);
        oresp = '0;

        // Both masters hold valid for four single-beat transactions
        req(0, 1, 0, A0, MLEN1);
        req(1, 1, 0, A1, MLEN1);
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("t3_grant_addr", oreq.addr, (order[t] == 0) ? A0 : A1);
            resp(1, 1, 32'h3300_0000 + t, order[t]);
            tick();
            oresp = '0;
            #1;
            chk("t3_bubble", 32'(oreq.valid), 32'd0);
        end
        req(0, 0, 0, A0, MLEN1);
        req(1, 0, 0, A1, MLEN1);
        tick();

        // Writeback burst with ready low every other cycle and early last during a stall
        req(1, 1, 1, A4, MLEN16);
        tick();
        chk("t4_is_write", 32'(oreq.is_write), 32'd1);
        seen0 = beats_seen;
        for (int c = 0; c < 32; c++) begin
            if (c == 3) req(0, 1, 0, A0, MLEN1);
            resp(logic'(c % 2), (c / 2) == 15, 32'h4400_0000 + c / 2, 1);
            #1;
            chk("t4_owner_held", oreq.addr, A4);
            tick();
        end
        chk("t4_beat_count", beats_seen - seen0, 32'd16);
        chk("t4_idle_after", 32'(dut.state_q), 32'(IDLE));
        req(1, 0, 1, A4, MLEN16);
        oresp = '0;
        tick();
        chk("t4_m0_after", oreq.addr, A0);
        resp(1, 1, 32'h4500_0000, 0);
        tick();
        req(0, 0, 0, A0, MLEN1);
        oresp = '0;
        tick();

        // Owner drops valid for three cycles mid-burst while master 0 waits
        req(1, 1, 0, A5, MLEN16);
        tick();
        for (int c = 0; c < 19; c++) begin
            if (c == 2) req(0, 1, 0, A0, MLEN1);
            if (c >= 5 && c < 8) begin
                ireqs[1].valid = 1'b0;
                oresp = '0;
                #1;
                chk("t5_gap_valid", 32'(oreq.valid), 32'd0);
                chk("t5_gap_m0_quiet", 32'(|iresps[0]), 32'd0);
            end else begin
                b = (c < 5) ? c : c - 3;
                ireqs[1].valid = 1'b1;
                resp(1, b == 15, 32'h5500_0000 + b, 1);
                #1;
                chk("t5_owner_addr", oreq.addr, A5);
            end
            tick();
        end
        req(1, 0, 0, A5, MLEN16);
        oresp = '0;
        #1;
        chk("t5_bubble", 32'(oreq.valid), 32'd0);
        tick();
        chk("t5_m0_granted", oreq.addr, A0);
        resp(1, 1, 32'h5600_0000, 0);
        tick();
        req(0, 0, 0, A0, MLEN1);
        oresp = '0;
        tick();

        // Reset asserted at beat 8 of a burst
        req(1, 1, 0, A6, MLEN16);
        tick();
        for (int i = 0; i < 8; i++) begin
            resp(1, 0, 32'h6600_0000 + i, 1);
            tick();
        end
        oresp = '{ready: 1'b1, last: 1'b0, data: 32'h6600_0008};
        #1;
        chk("t6_pre_reset_valid", 32'(oreq.valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_oreq_zero", 32'(|oreq), 32'd0);
        chk("t6_iresps_zero", 32'(resp_nz()), 32'd0);
        oresp = '0;
        req(1, 0, 0, A6, MLEN16);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("t6_state_idle", 32'(dut.state_q), 32'(IDLE));
        req(0, 1, 0, A0, MLEN1);
        #1;
        chk("t6_same_cycle_valid", 32'(oreq.valid), 32'd0);
        tick();
        chk("t6_latency_valid", 32'(oreq.valid), 32'd1);
        chk("t6_addr", oreq.addr, A0);
        resp(1, 1, 32'h6700_0000, 0);
        tick();
        req(0, 0, 0, A0, MLEN1);
        oresp = '0;
        tick();
        tick();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
